vga_text_motion_ctrl: RTL and testbench
=======================================

// Module: vga_text_motion_ctrl
// PURPOSE
//   Frame-synchronous controller for the VGA text path. It sits beside the
//   sync generator and the character generator.
//   - Counts frames from vsync.
//   - Moves the text block origin (text_x/text_y) with bounce-at-edge rules.
//   - Latches or auto-cycles the RGB text colour only at frame boundaries,
//     so no tearing is visible.
//   - Drives the position/colour configuration consumed by the letter generator.
// PARAMETERS
//   H_RES      640  visible width in pixels
//   V_RES      480  visible height in pixels
//   TEXT_W     128  text block width in pixels  (TEXT_W < H_RES)
//   TEXT_H     32   text block height in pixels (TEXT_H < V_RES)
//   STEP       2    pixels moved per update on each axis (1..TEXT_W)
//   FRAME_DIV  2    frames per position update (>=1)
//   X_INIT     256  reset value of text_x
//   Y_INIT     224  reset value of text_y
//   VSYNC_POL  0    active level of the vsync input (0 = active-low)
// PORTS
//   clk         in   1   system/pixel-domain clock
//   reset       in   1   asynchronous, active-high reset
//   vsync       in   1   vertical sync from the sync generator, same clk domain
//   enable      in   1   1 = motion running, 0 = position frozen
//   auto_color  in   1   1 = cycle colour each update, 0 = follow sw_rgb
//   sw_rgb      in   3   debounced colour switches
//   text_x      out  10  left edge of the text block, 0..H_RES-TEXT_W
//   text_y      out  10  top edge of the text block, 0..V_RES-TEXT_H
//   rgb_sel     out  3   text colour to the letter generator
//   frame_tick  out  1   one-clk pulse at each frame start
// BEHAVIOUR
//   Reset (asynchronous, dominates everything):
//     text_x=X_INIT, text_y=Y_INIT, rgb_sel=3'b111, frame_tick=0,
//     dir_x=+, dir_y=+, frame_cnt=0, vsync_q=inactive level.
//   Frame edge:
//     - vsync_q holds the previous sample of vsync.
//     - edge = (vsync==VSYNC_POL) && (vsync_q!=VSYNC_POL).
//     - On the clk edge where edge is true, frame_tick goes to 1 for exactly
//       one cycle. Every register below updates on that same edge.
//     - vsync held active for many cycles produces one tick only.
//   Frame counter:
//     - frame_cnt counts 0..FRAME_DIV-1 on ticks while enable=1, then wraps
//       to 0.
//     - update = tick && enable && (frame_cnt==FRAME_DIV-1).
//     - With enable=0, frame_cnt is held at 0.
//   FSM (2 states):
//     PAUSE: entered when enable=0; no position change.
//     RUN:   entered when enable=1; position moves on update.
//     - The state is re-evaluated on every clk, not only on ticks.
//     - If enable deasserts on the same edge as a tick, there is no move.
//   X axis on update (Y identical, using V_RES/TEXT_H/dir_y):
//     - dir_x=+: if text_x+STEP >= H_RES-TEXT_W, then text_x=H_RES-TEXT_W
//       and dir_x flips to -; else text_x += STEP.
//     - dir_x=-: if text_x <= STEP, then text_x=0 and dir_x flips to +;
//       else text_x -= STEP.
//     - Compare in 11 bits; no wrap-around is ever visible.
//   Colour (evaluated on every tick, independent of enable):
//     - auto_color=0: rgb_sel <= sw_rgb. The value 3'b000 is allowed.
//     - auto_color=1: on update, rgb_sel advances 001->010->...->111->001,
//       skipping 000. If rgb_sel==000 when auto_color=1 is first ticked,
//       it loads 001.
//     - auto_color is sampled only on ticks.
//   Timing: outputs change only on tick edges (or reset). Latency from the
//     active vsync sample to new text_x/text_y/rgb_sel is 1 clk.
// STRUCTURE
//   Package vga_pkg:
//     - H_RES, V_RES, PIX_W=10 constants.
//     - typedef pix_t = logic [PIX_W-1:0].
//     - typedef rgb_t = logic [2:0].
//     - enum {PAUSE, RUN} motion_state_t.
//   One sub-module, vga_frame_tick:
//     - vsync register and edge detect with VSYNC_POL.
//     - Outputs frame_tick; reusable by other frame-rate logic.
//   Axis update: one function instantiated twice (X and Y).
// TESTING
//   1. Reset mid-frame (pulse reset with vsync active) -> text_x=256,
//      text_y=224, rgb_sel=111, frame_tick=0 immediately, with no clk needed.
//   2. FRAME_DIV=2, enable=1, 4 vsync pulses -> frame_tick pulses 4 times,
//      each 1 clk wide. text_x steps 256->258->260 (two updates).
//      vsync held 2 lines -> still one tick.
//   3. Start text_x=510, dir +, STEP=2 -> next update text_x=512 with dir
//      flipped. Following update gives 510. Same check for text_y at 448
//      and at 0.
//   4. auto_color=0, sw_rgb changes 100->010 mid-frame -> rgb_sel changes
//      only on the next tick. auto_color=1 from rgb_sel=111 -> 001 -> 010.
//   5. enable dropped on a tick edge -> no move. Re-enable -> first move
//      after FRAME_DIV further ticks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA text path: screen constants, pixel and
// colour types, the motion state, and the bounce-at-edge axis step.
package vga_pkg;

   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int PIX_W = 10;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [2:0]       rgb_t;

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } motion_state_t;

   typedef struct packed {
      pix_t pos;
      logic dir_neg;
   } axis_t;

   // One position update on one axis. Compares are done one bit wider than the
   // pixel type so pos+step can never wrap and slip past the limit.
   function automatic axis_t axis_step(input pix_t pos, input logic dir_neg,
                                       input pix_t limit, input pix_t step);
      logic [PIX_W:0] sum;
      axis_t          r;
      sum       = {1'b0, pos} + {1'b0, step};
      r.pos     = pos;
      r.dir_neg = dir_neg;
      if (!dir_neg) begin
         if (sum >= {1'b0, limit}) begin
            r.pos     = limit;
            r.dir_neg = 1'b1;
         end else begin
            r.pos = sum[PIX_W-1:0];
         end
      end else begin
         if ({1'b0, pos} <= {1'b0, step}) begin
            r.pos     = '0;
            r.dir_neg = 1'b0;
         end else begin
            r.pos = pos - step;
         end
      end
      return r;
   endfunction

   // Auto-cycle order 001 -> ... -> 111 -> 001; black is never produced.
   function automatic rgb_t rgb_advance(input rgb_t c);
      return (c == 3'b111 || c == 3'b000) ? 3'b001 : c + 3'b001;
   endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-start detector: registers vsync and flags the first active sample of
// each vertical sync pulse, both as a same-cycle strobe and a registered tick.
module vga_frame_tick #(
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic frame_edge,
   output logic frame_tick
);

   logic vsync_q;

   assign frame_edge = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_q    <= ~VSYNC_POL;
         frame_tick <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         frame_tick <= frame_edge;
      end
   end

endmodule

// File: rtl/vga_text_motion_ctrl.sv
// Frame-synchronous motion and colour control for the text block: bounces the
// block origin around the visible area and changes colour only at frame starts.
//
//   state | meaning
//   PAUSE | enable low; frame counter held at 0, position frozen
//   RUN   | enable high; frame counter runs, position moves on update
module vga_text_motion_ctrl
   import vga_pkg::*;
#(
   parameter int   H_RES     = vga_pkg::H_RES,
   parameter int   V_RES     = vga_pkg::V_RES,
   parameter int   TEXT_W    = 128,
   parameter int   TEXT_H    = 32,
   parameter int   STEP      = 2,
   parameter int   FRAME_DIV = 2,
   parameter int   X_INIT    = 256,
   parameter int   Y_INIT    = 224,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   input  logic enable,
   input  logic auto_color,
   input  rgb_t sw_rgb,
   output pix_t text_x,
   output pix_t text_y,
   output rgb_t rgb_sel,
   output logic frame_tick
);

   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
   localparam pix_t X_MAX  = pix_t'(H_RES - TEXT_W);
   localparam pix_t Y_MAX  = pix_t'(V_RES - TEXT_H);
   localparam pix_t STEP_P = pix_t'(STEP);

   motion_state_t    state;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] cnt_wrap;
   logic             frame_edge;
   logic             update;
   logic             dir_x_neg;
   logic             dir_y_neg;
   axis_t            x_next;
   axis_t            y_next;

   vga_frame_tick #(
      .VSYNC_POL (VSYNC_POL)
   ) u_frame_tick (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .frame_edge (frame_edge),
      .frame_tick (frame_tick)
   );

   // Enable is used as sampled on the tick edge itself, so dropping it on that
   // edge suppresses the move even though the state still reads RUN.
   assign update   = frame_edge && enable && (frame_cnt == CNT_LAST);
   assign cnt_wrap = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
   assign x_next   = axis_step(text_x, dir_x_neg, X_MAX, STEP_P);
   assign y_next   = axis_step(text_y, dir_y_neg, Y_MAX, STEP_P);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= PAUSE;
         frame_cnt <= '0;
         text_x    <= pix_t'(X_INIT);
         text_y    <= pix_t'(Y_INIT);
         dir_x_neg <= 1'b0;
         dir_y_neg <= 1'b0;
         rgb_sel   <= 3'b111;
      end else begin
         state <= enable ? RUN : PAUSE;

         case (state)
            RUN: begin
               if (!enable)
                  frame_cnt <= '0;
               else if (frame_edge)
                  frame_cnt <= cnt_wrap;
            end
            PAUSE: begin
               if (enable && frame_edge)
                  frame_cnt <= cnt_wrap;
            end
            default: frame_cnt <= '0;
         endcase

         if (update) begin
            text_x    <= x_next.pos;
            dir_x_neg <= x_next.dir_neg;
            text_y    <= y_next.pos;
            dir_y_neg <= y_next.dir_neg;
         end

         if (frame_edge) begin
            if (!auto_color)
               rgb_sel <= sw_rgb;
            else if (rgb_sel == 3'b000 || update)
               rgb_sel <= rgb_advance(rgb_sel);
         end
      end
   end

endmodule

// File: tb/tb_vga_text_motion_ctrl.sv
// Randomised bench for vga_text_motion_ctrl with a behavioural model: position
// is derived from the number of updates as a triangle wave between the edges.
module tb_vga_text_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       enable;
   logic       auto_color;
   logic [2:0] sw_rgb;
   logic [9:0] text_x;
   logic [9:0] text_y;
   logic [2:0] rgb_sel;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   vga_text_motion_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .enable     (enable),
      .auto_color (auto_color),
      .sw_rgb     (sw_rgb),
      .text_x     (text_x),
      .text_y     (text_y),
      .rgb_sel    (rgb_sel),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Start at 256 = 128 steps above 0; travel 0..512 in steps of 2 => period 512.
   function automatic int xpos(input int n);
      int p;
      p = (128 + n) % 512;
      return (p <= 256) ? 2 * p : 2 * (512 - p);
   endfunction

   // Start at 224 = 112 steps above 0; travel 0..448 in steps of 2 => period 448.
   function automatic int ypos(input int n);
      int p;
      p = (112 + n) % 448;
      return (p <= 224) ? 2 * p : 2 * (448 - p);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model
   int         n_upd = 0;
   int         m_cnt = 0;
   bit         m_prev_active = 1'b0;
   bit         m_tick = 1'b0;
   logic [2:0] m_rgb = 3'b111;

   always @(posedge clk or posedge reset) begin
      bit active;
      bit tk;
      bit upd;
      if (reset) begin
         n_upd = 0; m_cnt = 0; m_prev_active = 1'b0; m_tick = 1'b0; m_rgb = 3'b111;
      end else begin
         active = (vsync == 1'b0);
         tk = active && !m_prev_active;
         m_prev_active = active;
         m_tick = tk;
         upd = 1'b0;
         if (!enable) m_cnt = 0;
         else if (tk) begin
            if (m_cnt == 1) begin upd = 1'b1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
         end
         if (upd) n_upd = n_upd + 1;
         if (tk) begin
            if (!auto_color) m_rgb = sw_rgb;
            else if (m_rgb == 3'b000) m_rgb = 3'b001;
            else if (upd) m_rgb = (m_rgb == 3'b111) ? 3'b001 : m_rgb + 3'b001;
         end
      end
   end

   int tick_seen = 0;
   bit ms[8];

   always @(negedge clk) begin
      if (!reset) begin
         chk("text_x", {22'd0, text_x}, xpos(n_upd));
         chk("text_y", {22'd0, text_y}, ypos(n_upd));
         chk("rgb_sel", {29'd0, rgb_sel}, {29'd0, m_rgb});
         chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
         if (frame_tick) tick_seen++;
         if (n_upd == 112 && !ms[0]) begin ms[0] = 1; chk("y_bounce_max", {22'd0, text_y}, 448); end
         if (n_upd == 113 && !ms[1]) begin ms[1] = 1; chk("y_after_max", {22'd0, text_y}, 446); end
         if (n_upd == 128 && !ms[2]) begin ms[2] = 1; chk("x_bounce_max", {22'd0, text_x}, 512); end
         if (n_upd == 129 && !ms[3]) begin ms[3] = 1; chk("x_after_max", {22'd0, text_x}, 510); end
         if (n_upd == 336 && !ms[4]) begin ms[4] = 1; chk("y_bounce_zero", {22'd0, text_y}, 0); end
         if (n_upd == 337 && !ms[5]) begin ms[5] = 1; chk("y_after_zero", {22'd0, text_y}, 2); end
         if (n_upd == 384 && !ms[6]) begin ms[6] = 1; chk("x_bounce_zero", {22'd0, text_x}, 0); end
         if (n_upd == 385 && !ms[7]) begin ms[7] = 1; chk("x_after_zero", {22'd0, text_x}, 2); end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int act, input int idle);
      vsync = 1'b0;
      repeat (act) step();
      vsync = 1'b1;
      repeat (idle) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; vsync = 1'b1; enable = 1'b1; auto_color = 1'b0; sw_rgb = 3'b100;
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();

      // Reset asserted mid-cycle while vsync is active and frame_tick is high.
      vsync = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_text_x", {22'd0, text_x}, 256);
      chk("rst_text_y", {22'd0, text_y}, 224);
      chk("rst_rgb", {29'd0, rgb_sel}, 7);
      chk("rst_tick", {31'd0, frame_tick}, 0);
      vsync = 1'b1;
      step(); step();
      reset = 1'b0;
      step();

      tick_seen = 0;
      repeat (4) frame(20, 6);
      chk("tick_count_4", tick_seen, 4);
      chk("x_after_4", {22'd0, text_x}, 260);
      chk("y_after_4", {22'd0, text_y}, 228);
      chk("rgb_sw_100", {29'd0, rgb_sel}, 4);

      sw_rgb = 3'b010;
      step();
      chk("rgb_hold_midframe", {29'd0, rgb_sel}, 4);
      frame(2, 4);
      chk("rgb_next_tick", {29'd0, rgb_sel}, 2);

      enable = 1'b0;
      frame(2, 4);
      chk("no_move_enable_drop", {22'd0, text_x}, 260);
      enable = 1'b1;
      frame(2, 4);
      chk("reenable_first_tick", {22'd0, text_x}, 260);
      frame(2, 4);
      chk("reenable_second_tick", {22'd0, text_x}, 262);

      sw_rgb = 3'b111;
      frame(2, 4);
      chk("rgb_sw_111", {29'd0, rgb_sel}, 7);
      auto_color = 1'b1;
      frame(2, 4);
      chk("auto_111_to_001", {29'd0, rgb_sel}, 1);
      chk("x_after_10", {22'd0, text_x}, 264);
      frame(2, 4);
      chk("auto_hold_001", {29'd0, rgb_sel}, 1);
      frame(2, 4);
      chk("auto_001_to_010", {29'd0, rgb_sel}, 2);
      chk("x_after_12", {22'd0, text_x}, 266);

      for (int f = 0; f < 3000; f++) begin
         int act;
         int idle;
         act  = $urandom_range(1, 4);
         idle = $urandom_range(1, 5);
         enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) auto_color = ~auto_color;
         if ($urandom_range(0, 1) == 0) sw_rgb = 3'($urandom_range(0, 7));
         vsync = 1'b0;
         repeat (act) step();
         vsync = 1'b1;
         step();
         if ($urandom_range(0, 3) == 0) sw_rgb = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) enable = ~enable;
         repeat (idle) step();
      end

      repeat (4) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
